// File: rtl/sprite_pkg.sv
// Shared constants, loader state encoding and address helper for the sprite attribute loader.
package sprite_pkg;

    localparam int          SPR_NUM_SPRITES = 8;
    localparam logic [15:0] SPR_ATTR_BASE   = 16'h4FF0;
    localparam logic [15:0] SPR_POS_BASE    = 16'h5060;

    typedef enum logic [3:0] {
        IDLE,
        NF_RD,
        NF_CAP,
        PI_RD,
        PI_CAP,
        PR_RD,
        PR_CAP,
        X_RD,
        X_CAP,
        Y_RD,
        Y_CAP
    } ldr_state_t;

    // Each sprite owns two consecutive bytes at a table base: base + 2*idx + second.
    function automatic logic [15:0] slot_addr(input logic [15:0] base,
                                              input logic [2:0]  idx,
                                              input logic        second);
        return base + {12'd0, idx, second};
    endfunction

endpackage

// File: rtl/palette_assembler.sv
// Collects four palette ROM bytes into a 32-bit word, first byte ending up in the top lane.
module palette_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_en,
    input  logic [7:0]  din,
    output logic [1:0]  k,
    output logic [31:0] palette,
    output logic        last_byte
);

    logic [1:0]  k_reg;
    logic [31:0] shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= 2'd0;
            shift_reg <= 32'd0;
        end else if (shift_en) begin
            k_reg     <= k_reg + 2'd1;
            shift_reg <= {shift_reg[23:0], din};
        end
    end

    assign k         = k_reg;
    assign palette   = shift_reg;
    assign last_byte = (k_reg == 2'd3);

endmodule

// File: rtl/sprite_attr_loader.sv
// Per-frame walker over sprite attribute RAM and palette ROM, issuing one-hot load strobes
// for the eight downstream sprite registers.
module sprite_attr_loader
    import sprite_pkg::*;
#(
    parameter int          NUM_SPRITES = SPR_NUM_SPRITES,
    parameter logic [15:0] ATTR_BASE   = SPR_ATTR_BASE,
    parameter logic [15:0] POS_BASE    = SPR_POS_BASE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vblank,
    input  logic [7:0]             sprite_RAM_din,
    output logic                   rd_en,
    output logic [15:0]            sprite_RAM_addr,
    input  logic [7:0]             pal_rom_din,
    output logic                   pal_rd_en,
    output logic [7:0]             pal_rom_addr,
    output logic [7:0]             fsm_dout,
    output logic [31:0]            palette_out,
    output logic [NUM_SPRITES-1:0] ld_x,
    output logic [NUM_SPRITES-1:0] ld_y,
    output logic [NUM_SPRITES-1:0] ld_num_flips,
    output logic [NUM_SPRITES-1:0] ld_palette,
    output logic                   busy,
    output logic                   done
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_SPRITES - 1);

    ldr_state_t             state_reg, state_next;
    logic [2:0]             idx_reg, idx_next;
    logic [15:0]            addr_reg, addr_next;
    logic [5:0]             pal_idx_reg;
    logic                   vblank_q;
    logic                   pal_last;
    logic [1:0]             pal_k;
    logic [NUM_SPRITES-1:0] sel;

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sel
        assign sel[gi] = (idx_reg == 3'(gi));
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE:    if (vblank && !vblank_q) state_next = NF_RD;
            NF_RD:   state_next = NF_CAP;
            NF_CAP:  state_next = PI_RD;
            PI_RD:   state_next = PI_CAP;
            PI_CAP:  state_next = PR_RD;
            PR_RD:   state_next = PR_CAP;
            PR_CAP:  state_next = pal_last ? X_RD : PR_RD;
            X_RD:    state_next = X_CAP;
            X_CAP:   state_next = Y_RD;
            Y_RD:    state_next = Y_CAP;
            Y_CAP: begin
                // idx wraps 7 -> 0 so the next pass always begins at sprite 0
                idx_next   = idx_reg + 3'd1;
                state_next = (idx_reg == LAST_IDX) ? IDLE : NF_RD;
            end
            default: state_next = IDLE;
        endcase
    end

    // The address is loaded on entry to a read state and otherwise holds.
    always_comb begin
        addr_next = addr_reg;
        case (state_next)
            NF_RD:   addr_next = slot_addr(ATTR_BASE, idx_next, 1'b0);
            PI_RD:   addr_next = slot_addr(ATTR_BASE, idx_next, 1'b1);
            X_RD:    addr_next = slot_addr(POS_BASE,  idx_next, 1'b0);
            Y_RD:    addr_next = slot_addr(POS_BASE,  idx_next, 1'b1);
            default: addr_next = addr_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= 3'd0;
            vblank_q     <= 1'b1;
            addr_reg     <= 16'd0;
            pal_idx_reg  <= 6'd0;
            fsm_dout     <= 8'd0;
            ld_num_flips <= '0;
            ld_palette   <= '0;
            ld_x         <= '0;
            ld_y         <= '0;
            done         <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            vblank_q     <= vblank;
            addr_reg     <= addr_next;
            ld_num_flips <= '0;
            ld_palette   <= '0;
            ld_x         <= '0;
            ld_y         <= '0;
            done         <= 1'b0;
            case (state_reg)
                NF_CAP: begin
                    fsm_dout     <= sprite_RAM_din;
                    ld_num_flips <= sel;
                end
                PI_CAP: begin
                    fsm_dout    <= sprite_RAM_din;
                    pal_idx_reg <= sprite_RAM_din[5:0];
                end
                PR_CAP: if (pal_last) ld_palette <= sel;
                X_CAP: begin
                    fsm_dout <= sprite_RAM_din;
                    ld_x     <= sel;
                end
                Y_CAP: begin
                    fsm_dout <= sprite_RAM_din;
                    ld_y     <= sel;
                    done     <= (idx_reg == LAST_IDX);
                end
                default: ;
            endcase
        end
    end

    palette_assembler u_pal (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (state_reg == PR_CAP),
        .din       (pal_rom_din),
        .k         (pal_k),
        .palette   (palette_out),
        .last_byte (pal_last)
    );

    assign rd_en           = (state_reg == NF_RD) || (state_reg == PI_RD) ||
                             (state_reg == X_RD)  || (state_reg == Y_RD);
    assign pal_rd_en       = (state_reg == PR_RD);
    assign busy            = (state_reg != IDLE);
    assign sprite_RAM_addr = addr_reg;
    assign pal_rom_addr    = {pal_idx_reg, pal_k};

endmodule
